seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (>= 4).
REQ-002 SHALL have parameter OPW, default 4, opcode width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port a, b  input  WIDTH each  operands.
REQ-008 SHALL have port ba  input  1  addend bit for ADDX/LEA.
REQ-009 SHALL have port op  input  OPW  opcode.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  registered result.
REQ-013 SHALL have port flags  output  4  {carry, zero, negative, overflow}, registered with result.
REQ-014 SHALL have port err  output  1  illegal opcode marker, registered with result.

Function
REQ-015 SHALL capture a, b, ba, op when in_valid && in_ready (accept).
REQ-016 SHALL implement opcodes: 0 ADD a+b; 1 ADDX a+ba+2b; 2 SUB a-b; 3 ADD2 a+2b; 4 MUL low WIDTH bits of a*b; 5 AND; 6 SHL a<<b; 7 LEA ba+2b; 8 OR; 9 XOR; 10 SHR logical a>>b.
REQ-017 SHALL return result 0 and err=1 for opcodes 11-15; other flags 0.
REQ-018 SHALL compute ADD-class ops in WIDTH+2 bits; carry = bit WIDTH of the sum; 2b truncated to WIDTH+1 bits before adding.
REQ-019 SHALL define SUB carry as no-borrow: bit WIDTH of {0,a}+{0,~b}+1.
REQ-020 SHALL set overflow only for ADD/SUB (signed two's-complement overflow); 0 for all other ops.
REQ-021 SHALL set zero = (result==0) and negative = result[WIDTH-1] for every legal op; carry 0 for non-add ops.
REQ-022 SHALL yield 0 for SHL/SHR when b >= WIDTH.
REQ-023 SHALL use FSM states IDLE, MUL, DONE.
REQ-024 IDLE: accept of non-MUL op -> DONE next cycle with result loaded (latency 1); accept of MUL -> MUL.
REQ-025 MUL: shift-add, one multiplier bit per cycle, WIDTH cycles, then DONE; out_valid asserted WIDTH+1 cycles after accept.
REQ-026 DONE: out_valid=1; result/flags/err stable until out_valid && out_ready.
REQ-027 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready); simultaneous result handoff and new accept in DONE is legal, giving back-to-back single-cycle throughput.
REQ-028 DONE with out_ready and no accept -> IDLE; out_valid drops next cycle.
REQ-029 in_ready SHALL be 0 throughout MUL; inputs ignored.

Reset
REQ-030 On rst: state IDLE, out_valid 0, result 0, flags 0, err 0, multiplier registers 0; in_ready 1 after reset deasserts.
REQ-031 rst mid-MUL or in DONE SHALL discard the operation; no result is produced.

Structure
REQ-032 Package alu_pkg SHALL hold the opcode enum, FSM state enum and flag bit-index constants.
REQ-033 The iterative multiplier SHALL be sub-module alu_mul_iter (start, a, b -> done, product[WIDTH-1:0]).

Verification (WIDTH=16)
REQ-034 ADD a=0xFFFF b=0x0001 -> result 0x0000, carry 1, zero 1, overflow 0, out_valid 1 cycle after accept.
REQ-035 SUB a=0x8000 b=0x0001 -> 0x7FFF, overflow 1, carry 1, negative 0.
REQ-036 MUL a=0x0003 b=0x0005 -> 0x000F after 17 cycles; in_ready 0 for 16 cycles; MUL 0x0100*0x0100 -> 0x0000, zero 1.
REQ-037 SHL a=1 b=15 -> 0x8000 negative 1; b=16 -> 0x0000 zero 1; op 0xF -> err 1, result 0.
REQ-038 out_ready held 0 for 3 cycles in DONE -> result stable, in_ready 0; back-to-back ADDs with out_ready=1 -> one result per cycle.
REQ-039 rst pulse at cycle 5 of MUL -> out_valid 0, state IDLE, no stale result after release.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   opcode_t - operation encodings carried on the op input
//   state_t  - control FSM states of seq_alu
//   FLAG_*   - bit positions inside the 4-bit flags output {carry, zero, negative, overflow}
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADDX = 4'd1,
        OP_SUB  = 4'd2,
        OP_ADD2 = 4'd3,
        OP_MUL  = 4'd4,
        OP_AND  = 4'd5,
        OP_SHL  = 4'd6,
        OP_LEA  = 4'd7,
        OP_OR   = 4'd8,
        OP_XOR  = 4'd9,
        OP_SHR  = 4'd10
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, low WIDTH bits of a*b.
//   clk, rst - clock, asynchronous active-high reset
//   start    - load operands (also performs the first multiplier bit)
//   a, b     - multiplicand, multiplier
//   done     - product valid (high for one cycle, WIDTH cycles after start)
//   product  - low WIDTH bits of a*b
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CW-1:0]    count_reg;
    logic             busy_reg;

    // Bit 0 of the multiplier is consumed while loading, so the remaining
    // WIDTH-1 bits take WIDTH-1 further cycles: WIDTH cycles in total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            acc_reg    <= b[0] ? a : '0;
            mcand_reg  <= a << 1;
            mplier_reg <= b >> 1;
            count_reg  <= CW'(WIDTH - 1);
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            if (count_reg == '0) begin
                busy_reg <= 1'b0;
            end else begin
                if (mplier_reg[0]) begin
                    acc_reg <= acc_reg + mcand_reg;
                end
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                count_reg  <= count_reg - CW'(1);
            end
        end
    end

    assign done    = busy_reg && (count_reg == '0);
    assign product = acc_reg;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: valid/ready ALU with single-cycle ops and an iterative multiply.
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid / in_ready  - request handshake; a, b, ba, op captured on accept
//   out_valid / out_ready- result handshake
//   result, flags, err   - registered result, {carry, zero, negative, overflow}, illegal-op marker
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ba,
    input  logic [OPW-1:0]   op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);

    import alu_pkg::*;

    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

    state_t           state_reg, state_next;
    logic             accept;
    logic             is_mul;
    logic             op_high_clear;
    opcode_t          opcode;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [3:0]       mul_flags;

    logic [WIDTH-1:0] result_reg;
    logic [3:0]       flags_reg;
    logic             err_reg;

    // Add-class datapath: WIDTH+2 bits so ADDX/LEA (a + ba + 2b) never wrap.
    logic [WIDTH+1:0] a_ext, b_ext, nb_ext, b2_ext, ba_ext, one_ext;
    logic [WIDTH+1:0] sum_ext;
    logic             unused_sum_msb;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;
    logic             alu_c, alu_v, alu_err;

    // Opcodes wider than 4 bits are only legal when the upper bits are zero.
    assign op_high_clear = ((op >> 4) == '0);
    assign opcode        = opcode_t'(op[3:0]);
    assign is_mul        = op_high_clear && (opcode == OP_MUL);

    assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == ST_DONE);

    assign a_ext   = {2'b00, a};
    assign b_ext   = {2'b00, b};
    assign nb_ext  = {2'b00, ~b};
    assign b2_ext  = {1'b0, b, 1'b0};
    assign ba_ext  = {{(WIDTH+1){1'b0}}, ba};
    assign one_ext = {{(WIDTH+1){1'b0}}, 1'b1};
    assign unused_sum_msb = sum_ext[WIDTH+1];

    always_comb begin
        sum_ext = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        if (!op_high_clear) begin
            alu_err = 1'b1;
        end else begin
            case (opcode)
                OP_ADD: begin
                    sum_ext = a_ext + b_ext;
                    alu_res = sum_ext[WIDTH-1:0];
                    alu_c   = sum_ext[WIDTH];
                    alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
                end
                OP_ADDX: begin
                    sum_ext = a_ext + ba_ext + b2_ext;
                    alu_res = sum_ext[WIDTH-1:0];
                    alu_c   = sum_ext[WIDTH];
                end
                OP_SUB: begin
                    // Carry is "no borrow": bit WIDTH of a + ~b + 1.
                    sum_ext = a_ext + nb_ext + one_ext;
                    alu_res = sum_ext[WIDTH-1:0];
                    alu_c   = sum_ext[WIDTH];
                    alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
                end
                OP_ADD2: begin
                    sum_ext = a_ext + b2_ext;
                    alu_res = sum_ext[WIDTH-1:0];
                    alu_c   = sum_ext[WIDTH];
                end
                OP_LEA: begin
                    sum_ext = ba_ext + b2_ext;
                    alu_res = sum_ext[WIDTH-1:0];
                    alu_c   = sum_ext[WIDTH];
                end
                OP_MUL: alu_res = '0;
                OP_AND: alu_res = a & b;
                OP_OR:  alu_res = a | b;
                OP_XOR: alu_res = a ^ b;
                OP_SHL: alu_res = (b >= SHIFT_LIMIT) ? '0 : (a << b);
                OP_SHR: alu_res = (b >= SHIFT_LIMIT) ? '0 : (a >> b);
                default: alu_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        alu_flags = '0;
        if (!alu_err) begin
            alu_flags[FLAG_C] = alu_c;
            alu_flags[FLAG_Z] = (alu_res == '0);
            alu_flags[FLAG_N] = alu_res[WIDTH-1];
            alu_flags[FLAG_V] = alu_v;
        end
    end

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_product == '0);
        mul_flags[FLAG_N] = mul_product[WIDTH-1];
    end

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = is_mul ? ST_MUL : ST_DONE;
            end
            ST_MUL: begin
                if (mul_done) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (accept)         state_next = is_mul ? ST_MUL : ST_DONE;
                else if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Single-cycle ops load at the accept edge; a multiply loads when the
    // iterative unit finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg <= '0;
            flags_reg  <= '0;
            err_reg    <= 1'b0;
        end else if (accept && !is_mul) begin
            result_reg <= alu_res;
            flags_reg  <= alu_flags;
            err_reg    <= alu_err;
        end else if ((state_reg == ST_MUL) && mul_done) begin
            result_reg <= mul_product;
            flags_reg  <= mul_flags;
            err_reg    <= 1'b0;
        end
    end

    assign result = result_reg;
    assign flags  = flags_reg;
    assign err    = err_reg;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (WIDTH=16).
// The driver pushes expected results as requests are accepted; the monitor
// pops and compares on every output handshake. Cycle-level observations made
// by the driver are queued as side checks and compared by the same monitor.
module tb_seq_alu;

    import alu_pkg::*;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [15:0] a         = '0;
    logic [15:0] b         = '0;
    logic        ba        = 1'b0;
    logic [3:0]  op        = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        err;

    typedef struct {
        logic [15:0] result;
        logic [3:0]  flags;
        logic        err;
        string       name;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] expv;
    } side_t;

    exp_t  exp_q[$];
    side_t side_q[$];
    int    checks   = 0;
    int    failures = 0;

    seq_alu #(
        .WIDTH (16),
        .OPW   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ba        (ba),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Monitor: result handshakes against the scoreboard, then queued side checks.
    always @(negedge clk) begin
        exp_t  e;
        side_t s;
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got result=%h flags=%b err=%b, required no output",
                         result, flags, err);
            end else begin
                e = exp_q.pop_front();
                if (result !== e.result || flags !== e.flags || err !== e.err) begin
                    failures++;
                    $display("FAIL %s got result=%h flags=%b err=%b, required result=%h flags=%b err=%b",
                             e.name, result, flags, err, e.result, e.flags, e.err);
                end else begin
                    $display("txn %s result=%h flags=%b err=%b ok", e.name, result, flags, err);
                end
            end
        end
        while (side_q.size() > 0) begin
            s = side_q.pop_front();
            checks++;
            if (s.act !== s.expv) begin
                failures++;
                $display("FAIL %s got %0h, required %0h", s.name, s.act, s.expv);
            end
        end
    end

    task automatic side(input string nm, input logic [31:0] act, input logic [31:0] expv);
        side_q.push_back('{name: nm, act: act, expv: expv});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Present a request, wait (bounded) for acceptance, return just after the accept edge.
    task automatic issue(input logic [3:0] op_i, input logic [15:0] a_i, input logic [15:0] b_i,
                         input logic ba_i, input bit push, input logic [15:0] er,
                         input logic [3:0] ef, input logic ee, input string nm, output int waited);
        waited   = 0;
        op       = op_i;
        a        = a_i;
        b        = b_i;
        ba       = ba_i;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) side({nm, "_accept_timeout"}, 32'd0, 32'd1);
        else if (push) exp_q.push_back('{result: er, flags: ef, err: ee, name: nm});
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [3:0] op_i, input logic [15:0] a_i, input logic [15:0] b_i,
                       input logic ba_i, input logic [15:0] er, input logic [3:0] ef,
                       input logic ee, input string nm);
        int w;
        step();
        issue(op_i, a_i, b_i, ba_i, 1'b1, er, ef, ee, nm, w);
        idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int guard;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        side("rst_out_valid", 32'(out_valid), 32'd0);
        side("rst_result",    32'(result),    32'd0);
        side("rst_flags",     32'(flags),     32'd0);
        side("rst_err",       32'(err),       32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        side("post_rst_in_ready", 32'(in_ready), 32'd1);

        // ADD with carry out, latency 1
        step();
        issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 4'b1100, 1'b0, "add_carry", w);
        idle();
        @(negedge clk);
        side("add_latency_valid", 32'(out_valid), 32'd1);

        // MUL latency and busy window
        step();
        issue(OP_MUL, 16'h0003, 16'h0005, 1'b0, 1'b1, 16'h000F, 4'b0000, 1'b0, "mul_3x5", w);
        idle();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            side("mul_busy_ready_valid", {30'd0, in_ready, out_valid}, 32'd0);
        end
        @(negedge clk);
        side("mul_latency_valid", 32'(out_valid), 32'd1);

        run(OP_MUL,  16'h0100, 16'h0100, 1'b0, 16'h0000, 4'b0100, 1'b0, "mul_zero");
        run(OP_MUL,  16'h1234, 16'h0011, 1'b0, 16'h3574, 4'b0000, 1'b0, "mul_1234x11");
        run(OP_SUB,  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b1001, 1'b0, "sub_ovf");
        run(OP_ADDX, 16'h0001, 16'h0002, 1'b1, 16'h0006, 4'b0000, 1'b0, "addx");
        run(OP_ADD2, 16'hFFFF, 16'h8000, 1'b0, 16'hFFFF, 4'b1010, 1'b0, "add2_carry");
        run(OP_LEA,  16'hFFFF, 16'h8000, 1'b1, 16'h0001, 4'b1000, 1'b0, "lea_carry");
        run(OP_AND,  16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 4'b0010, 1'b0, "and");
        run(OP_OR,   16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 4'b0000, 1'b0, "or");
        run(OP_XOR,  16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 4'b0100, 1'b0, "xor_zero");
        run(OP_SHL,  16'h0001, 16'h000F, 1'b0, 16'h8000, 4'b0010, 1'b0, "shl_15");
        run(OP_SHL,  16'h0001, 16'h0010, 1'b0, 16'h0000, 4'b0100, 1'b0, "shl_16");
        run(OP_SHR,  16'h8000, 16'h000F, 1'b0, 16'h0001, 4'b0000, 1'b0, "shr_15");
        run(OP_SHR,  16'h8000, 16'h0100, 1'b0, 16'h0000, 4'b0100, 1'b0, "shr_big");
        run(4'hF,    16'h1234, 16'h5678, 1'b0, 16'h0000, 4'b0000, 1'b1, "illegal_f");
        run(4'hB,    16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 4'b0000, 1'b1, "illegal_b");

        // Consumer stall: result held, no new accept
        step();
        out_ready = 1'b0;
        issue(OP_ADD, 16'h1234, 16'h0001, 1'b0, 1'b1, 16'h1235, 4'b0000, 1'b0, "add_stalled", w);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            side("stall_out_valid", 32'(out_valid), 32'd1);
            side("stall_in_ready",  32'(in_ready),  32'd0);
            side("stall_result",    32'(result),    32'h1235);
        end
        step();
        out_ready = 1'b1;

        // Back-to-back single-cycle throughput
        issue(OP_ADD, 16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0003, 4'b0000, 1'b0, "b2b_0", w);
        side("b2b_0_wait", 32'(w), 32'd0);
        issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 4'b0011, 1'b0, "b2b_1", w);
        side("b2b_1_wait", 32'(w), 32'd0);
        issue(OP_ADD, 16'h0F0F, 16'hF0F0, 1'b0, 1'b1, 16'hFFFF, 4'b0010, 1'b0, "b2b_2", w);
        side("b2b_2_wait", 32'(w), 32'd0);
        issue(OP_ADD, 16'h0005, 16'hFFFB, 1'b0, 1'b1, 16'h0000, 4'b1100, 1'b0, "b2b_3", w);
        side("b2b_3_wait", 32'(w), 32'd0);
        idle();

        // Reset during a multiply discards it
        step();
        issue(OP_MUL, 16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, "mul_aborted", w);
        idle();
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        side("rstmul_out_valid", 32'(out_valid), 32'd0);
        side("rstmul_result",    32'(result),    32'd0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            side("rstmul_no_result", 32'(out_valid), 32'd0);
        end
        side("rstmul_idle_ready", 32'(in_ready), 32'd1);
        run(OP_ADD, 16'h0002, 16'h0002, 1'b0, 16'h0004, 4'b0000, 1'b0, "add_after_rst");

        // Drain
        step();
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) side("drain_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
